// File: rtl/wb_commit_unit_pkg.sv
// ============================================================================
// Module : wb_commit_unit_pkg
// Brief  : Shared core types for the writeback/commit stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_commit_unit_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 64;

    typedef logic [XLEN-1:0] reg_data_t;
    typedef logic [4:0]      except_code_t;

    localparam except_code_t EXCEPT_ILLEGAL = 5'd2;
    // Not an architectural cause: marks a resolved branch mispredict.
    localparam except_code_t EXCEPT_MISPRED = 5'd31;

    typedef struct packed {
        logic [4:0] rd;
        logic       wb_en;
    } decode_t;

    typedef struct packed {
        logic         valid;
        except_code_t code;
        reg_data_t    target;
    } except_t;

    typedef struct packed {
        logic      valid;
        reg_data_t pc;
        decode_t   decode;
        except_t   except;
    } issued_instr_t;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH     = 2'd1,
        TRAP_WAIT = 2'd2
    } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_commit_unit_perf_counter64.sv
// ============================================================================
// Module : perf_counter64
// Brief  : Free-running 64-bit event counter with enable; wraps silently.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_counter64
    import wb_commit_unit_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/wb_commit_unit.sv
// ============================================================================
// Module : wb_commit_unit
// Brief  : Writeback/commit stage: RF write, retire/squash, flush/redirect/trap.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_commit_unit
    import wb_commit_unit_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  issued_instr_t i_instr,
    input  reg_data_t     i_data,
    input  logic          i_trap_ack,
    input  reg_data_t     i_trap_vec,
    input  logic [31:0]   i_log_fd,
    output logic          o_rf_wr_en,
    output logic [4:0]    o_rf_wr_idx,
    output reg_data_t     o_rf_wr_data,
    output logic          o_flush,
    output logic          o_redirect_valid,
    output reg_data_t     o_redirect_pc,
    output logic          o_trap_valid,
    output except_code_t  o_trap_code,
    output reg_data_t     o_trap_pc,
    output logic [63:0]   o_cycle,
    output logic [63:0]   o_instret
);

    wb_state_t r_state;
    logic      w_live;
    logic      w_mispred;
    logic      w_retire;

    // Reset gates acceptance so the RF port stays quiet while held in reset.
    assign w_live    = i_rst_n & (r_state == RUN) & i_instr.valid;
    assign w_mispred = i_instr.except.valid & (i_instr.except.code == EXCEPT_MISPRED);
    assign w_retire  = w_live & (~i_instr.except.valid | w_mispred);

    assign o_rf_wr_en   = w_retire & i_instr.decode.wb_en & (i_instr.decode.rd != 5'd0);
    assign o_rf_wr_idx  = o_rf_wr_en ? i_instr.decode.rd : 5'd0;
    assign o_rf_wr_data = o_rf_wr_en ? i_data : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= RUN;
            o_flush          <= 1'b0;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
            o_trap_valid     <= 1'b0;
            o_trap_code      <= '0;
            o_trap_pc        <= '0;
        end else begin
            o_flush          <= 1'b0;
            o_redirect_valid <= 1'b0;
            o_trap_valid     <= 1'b0;
            case (r_state)
                RUN: begin
                    if (w_live && i_instr.except.valid) begin
                        o_flush <= 1'b1;
                        if (w_mispred) begin
                            o_redirect_valid <= 1'b1;
                            o_redirect_pc    <= i_instr.except.target;
                            r_state          <= FLUSH;
                        end else begin
                            o_trap_valid <= 1'b1;
                            o_trap_code  <= i_instr.except.code;
                            o_trap_pc    <= i_instr.pc;
                            r_state      <= TRAP_WAIT;
                        end
                    end
                end
                FLUSH: begin
                    r_state <= RUN;
                end
                TRAP_WAIT: begin
                    if (i_trap_ack) begin
                        o_flush          <= 1'b1;
                        o_redirect_valid <= 1'b1;
                        o_redirect_pc    <= i_trap_vec;
                        r_state          <= FLUSH;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    perf_counter64 u_cycle_ctr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (1'b1),
        .o_count (o_cycle)
    );

    perf_counter64 u_instret_ctr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_retire),
        .o_count (o_instret)
    );

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_log_fd != 32'd0) begin
            $display("[WB] v=%0d pc=%h st=%0d we=%0d rd=%0d wd=%h fl=%0d rv=%0d rpc=%h tv=%0d tc=%0d",
                     i_instr.valid, i_instr.pc, r_state, o_rf_wr_en, o_rf_wr_idx, o_rf_wr_data,
                     o_flush, o_redirect_valid, o_redirect_pc, o_trap_valid, o_trap_code);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
// ============================================================================
// Module : tb_wb_commit_unit
// Brief  : Directed and randomized checks of wb_commit_unit against a rule model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_wb_commit_unit;
    import wb_commit_unit_pkg::*;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    issued_instr_t i_instr;
    reg_data_t     i_data;
    logic          i_trap_ack;
    reg_data_t     i_trap_vec;
    logic [31:0]   i_log_fd;
    logic          o_rf_wr_en;
    logic [4:0]    o_rf_wr_idx;
    reg_data_t     o_rf_wr_data;
    logic          o_flush;
    logic          o_redirect_valid;
    reg_data_t     o_redirect_pc;
    logic          o_trap_valid;
    except_code_t  o_trap_code;
    reg_data_t     o_trap_pc;
    logic [63:0]   o_cycle;
    logic [63:0]   o_instret;

    wb_commit_unit dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr), .i_data(i_data),
        .i_trap_ack(i_trap_ack), .i_trap_vec(i_trap_vec), .i_log_fd(i_log_fd),
        .o_rf_wr_en(o_rf_wr_en), .o_rf_wr_idx(o_rf_wr_idx), .o_rf_wr_data(o_rf_wr_data),
        .o_flush(o_flush), .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
        .o_trap_valid(o_trap_valid), .o_trap_code(o_trap_code), .o_trap_pc(o_trap_pc),
        .o_cycle(o_cycle), .o_instret(o_instret)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: inputs are dropped while a flush pulse is visible or a trap awaits its ack.
    longint unsigned m_cycle, m_instret;
    bit              m_waiting, m_retire_pend;
    bit              e_wr_en;
    logic [4:0]      e_wr_idx;
    reg_data_t       e_wr_data;
    bit              e_flush, e_redir, e_trap;
    reg_data_t       e_redir_pc, e_trap_pc;
    except_code_t    e_trap_code;
    bit              n_flush, n_redir, n_trap, n_waiting;
    reg_data_t       n_redir_pc, n_trap_pc;
    except_code_t    n_trap_code;

    function automatic issued_instr_t mk(bit v, reg_data_t pc, logic [4:0] rd, bit wb,
                                         bit ev, except_code_t code, reg_data_t tgt);
        issued_instr_t t;
        t = '0;
        t.valid = v; t.pc = pc; t.decode.rd = rd; t.decode.wb_en = wb;
        t.except.valid = ev; t.except.code = code; t.except.target = tgt;
        return t;
    endfunction

    task automatic model_reset();
        m_cycle = 0; m_instret = 0; m_waiting = 0; m_retire_pend = 0;
        e_wr_en = 0; e_wr_idx = '0; e_wr_data = '0;
        e_flush = 0; e_redir = 0; e_trap = 0;
        e_redir_pc = '0; e_trap_pc = '0; e_trap_code = '0;
    endtask

    task automatic drive(input issued_instr_t ins, input reg_data_t d, input logic ack, input reg_data_t vec);
        bit accept;
        i_instr = ins; i_data = d; i_trap_ack = ack; i_trap_vec = vec;
        accept = !e_flush && !m_waiting;
        n_flush = 0; n_redir = 0; n_trap = 0; n_waiting = m_waiting;
        n_redir_pc = e_redir_pc; n_trap_pc = e_trap_pc; n_trap_code = e_trap_code;
        m_retire_pend = 0; e_wr_en = 0; e_wr_idx = '0; e_wr_data = '0;
        if (accept && ins.valid) begin
            if (!ins.except.valid || ins.except.code == EXCEPT_MISPRED) begin
                m_retire_pend = 1;
                e_wr_en = ins.decode.wb_en && (ins.decode.rd != 5'd0);
                if (e_wr_en) begin
                    e_wr_idx = ins.decode.rd; e_wr_data = d;
                end
                if (ins.except.valid) begin
                    n_flush = 1; n_redir = 1; n_redir_pc = ins.except.target;
                end
            end else begin
                n_flush = 1; n_trap = 1; n_trap_code = ins.except.code;
                n_trap_pc = ins.pc; n_waiting = 1;
            end
        end else if (m_waiting && ack) begin
            n_flush = 1; n_redir = 1; n_redir_pc = vec; n_waiting = 0;
        end
        #1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        m_cycle++;
        if (m_retire_pend) m_instret++;
        m_retire_pend = 0;
        e_flush = n_flush; e_redir = n_redir; e_trap = n_trap; m_waiting = n_waiting;
        e_redir_pc = n_redir_pc; e_trap_pc = n_trap_pc; e_trap_code = n_trap_code;
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge i_clk);
        #1;
        checks++; if (o_flush !== 1'b0 || o_redirect_valid !== 1'b0 || o_trap_valid !== 1'b0) begin
            errors++; $display("FAIL rst_pulses: got fl=%0b rv=%0b tv=%0b want 0", o_flush, o_redirect_valid, o_trap_valid); end
        checks++; if (o_redirect_pc !== '0 || o_trap_pc !== '0 || o_trap_code !== '0) begin
            errors++; $display("FAIL rst_regs: got rpc=%h tpc=%h tc=%0d want 0", o_redirect_pc, o_trap_pc, o_trap_code); end
        checks++; if (o_cycle !== 64'd0 || o_instret !== 64'd0) begin
            errors++; $display("FAIL rst_ctr: got cyc=%0d ins=%0d want 0", o_cycle, o_instret); end
        checks++; if (o_rf_wr_en !== 1'b0 || o_rf_wr_idx !== 5'd0 || o_rf_wr_data !== '0) begin
            errors++; $display("FAIL rst_rf: got we=%0b idx=%0d wd=%h want 0", o_rf_wr_en, o_rf_wr_idx, o_rf_wr_data); end
        i_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive('0, '0, 1'b0, '0);
            tick();
        end
        checks++; if (o_cycle !== 64'd10 || o_instret !== 64'd0) begin
            errors++; $display("FAIL idle_ctr: got cyc=%0d ins=%0d want 10/0", o_cycle, o_instret); end
        checks++; if (o_flush !== 1'b0 || o_trap_valid !== 1'b0) begin
            errors++; $display("FAIL idle_pulses: got fl=%0b tv=%0b want 0", o_flush, o_trap_valid); end
    endtask

    task automatic test_normal_write();
        longint unsigned i0 = m_instret;
        drive(mk(1, 64'h100, 5'd5, 1, 0, '0, '0), 64'hDEAD, 1'b0, '0);
        checks++; if (o_rf_wr_en !== 1'b1 || o_rf_wr_idx !== 5'd5 || o_rf_wr_data !== 64'hDEAD) begin
            errors++; $display("FAIL wr_rd5: got we=%0b idx=%0d wd=%h want 1/5/dead", o_rf_wr_en, o_rf_wr_idx, o_rf_wr_data); end
        tick();
        checks++; if (o_instret !== i0 + 1) begin
            errors++; $display("FAIL wr_instret: got %0d want %0d", o_instret, i0 + 1); end
        drive(mk(1, 64'h104, 5'd0, 1, 0, '0, '0), 64'h1234, 1'b0, '0);
        checks++; if (o_rf_wr_en !== 1'b0) begin
            errors++; $display("FAIL wr_rd0: got we=%0b want 0", o_rf_wr_en); end
        tick();
        checks++; if (o_instret !== i0 + 2) begin
            errors++; $display("FAIL rd0_instret: got %0d want %0d", o_instret, i0 + 2); end
    endtask

    task automatic test_mispredict();
        longint unsigned i0 = m_instret;
        drive(mk(1, 64'h200, 5'd1, 1, 1, EXCEPT_MISPRED, 64'h8000_0100), 64'h204, 1'b0, '0);
        checks++; if (o_rf_wr_en !== 1'b1 || o_rf_wr_idx !== 5'd1 || o_rf_wr_data !== 64'h204) begin
            errors++; $display("FAIL mp_link: got we=%0b idx=%0d wd=%h want 1/1/204", o_rf_wr_en, o_rf_wr_idx, o_rf_wr_data); end
        tick();
        checks++; if (o_flush !== 1'b1 || o_redirect_valid !== 1'b1 || o_redirect_pc !== 64'h8000_0100 || o_trap_valid !== 1'b0) begin
            errors++; $display("FAIL mp_redirect: got fl=%0b rv=%0b rpc=%h tv=%0b want 1/1/80000100/0",
                               o_flush, o_redirect_valid, o_redirect_pc, o_trap_valid); end
        drive(mk(1, 64'h8000_0100, 5'd2, 1, 0, '0, '0), 64'h22, 1'b0, '0);
        checks++; if (o_rf_wr_en !== 1'b0) begin
            errors++; $display("FAIL mp_squash: got we=%0b want 0", o_rf_wr_en); end
        tick();
        checks++; if (o_flush !== 1'b0 || o_redirect_valid !== 1'b0 || o_instret !== i0 + 1) begin
            errors++; $display("FAIL mp_after: got fl=%0b rv=%0b ins=%0d want 0/0/%0d", o_flush, o_redirect_valid, o_instret, i0 + 1); end
        drive(mk(1, 64'h8000_0104, 5'd3, 1, 0, '0, '0), 64'h33, 1'b0, '0);
        checks++; if (o_rf_wr_en !== 1'b1 || o_rf_wr_idx !== 5'd3) begin
            errors++; $display("FAIL mp_resume: got we=%0b idx=%0d want 1/3", o_rf_wr_en, o_rf_wr_idx); end
        tick();
        checks++; if (o_instret !== i0 + 2) begin
            errors++; $display("FAIL mp_instret: got %0d want %0d", o_instret, i0 + 2); end
    endtask

    task automatic test_trap();
        longint unsigned i0 = m_instret;
        drive(mk(1, 64'h1000, 5'd4, 1, 1, EXCEPT_ILLEGAL, '0), 64'hBEEF, 1'b0, '0);
        checks++; if (o_rf_wr_en !== 1'b0) begin
            errors++; $display("FAIL trap_nowr: got we=%0b want 0", o_rf_wr_en); end
        tick();
        checks++; if (o_trap_valid !== 1'b1 || o_trap_pc !== 64'h1000 || o_trap_code !== EXCEPT_ILLEGAL
                      || o_flush !== 1'b1 || o_redirect_valid !== 1'b0 || o_instret !== i0) begin
            errors++; $display("FAIL trap_req: got tv=%0b tpc=%h tc=%0d fl=%0b rv=%0b ins=%0d want 1/1000/2/1/0/%0d",
                               o_trap_valid, o_trap_pc, o_trap_code, o_flush, o_redirect_valid, o_instret, i0); end
        for (int i = 0; i < 3; i++) begin
            drive(mk(1, 64'h1004 + 64'(4 * i), 5'd6, 1, 0, '0, '0), 64'h66, 1'b0, '0);
            checks++; if (o_rf_wr_en !== 1'b0) begin
                errors++; $display("FAIL trap_ignore[%0d]: got we=%0b want 0", i, o_rf_wr_en); end
            tick();
            checks++; if (o_flush !== 1'b0 || o_trap_valid !== 1'b0 || o_instret !== i0) begin
                errors++; $display("FAIL trap_wait[%0d]: got fl=%0b tv=%0b ins=%0d want 0/0/%0d", i, o_flush, o_trap_valid, o_instret, i0); end
        end
        drive('0, '0, 1'b1, 64'h2000);
        tick();
        checks++; if (o_flush !== 1'b1 || o_redirect_valid !== 1'b1 || o_redirect_pc !== 64'h2000) begin
            errors++; $display("FAIL trap_vec: got fl=%0b rv=%0b rpc=%h want 1/1/2000", o_flush, o_redirect_valid, o_redirect_pc); end
        drive(mk(1, 64'h2000, 5'd7, 1, 0, '0, '0), 64'h77, 1'b0, '0);
        checks++; if (o_rf_wr_en !== 1'b0) begin
            errors++; $display("FAIL trap_flushsq: got we=%0b want 0", o_rf_wr_en); end
        tick();
        drive(mk(1, 64'h2000, 5'd7, 1, 0, '0, '0), 64'h77, 1'b0, '0);
        checks++; if (o_rf_wr_en !== 1'b1 || o_rf_wr_idx !== 5'd7) begin
            errors++; $display("FAIL trap_resume: got we=%0b idx=%0d want 1/7", o_rf_wr_en, o_rf_wr_idx); end
        tick();
        checks++; if (o_instret !== i0 + 1 || o_redirect_valid !== 1'b0) begin
            errors++; $display("FAIL trap_done: got ins=%0d rv=%0b want %0d/0", o_instret, o_redirect_valid, i0 + 1); end
    endtask

    task automatic test_reset_in_trap_wait();
        drive(mk(1, 64'h3000, 5'd8, 1, 1, 5'd5, '0), '0, 1'b0, '0);
        tick();
        drive('0, '0, 1'b0, '0);
        tick();
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (o_flush !== 1'b0 || o_redirect_valid !== 1'b0 || o_trap_valid !== 1'b0 || o_trap_pc !== '0
                      || o_trap_code !== '0 || o_redirect_pc !== '0 || o_cycle !== 64'd0 || o_instret !== 64'd0
                      || o_rf_wr_en !== 1'b0) begin
            errors++; $display("FAIL async_rst: got fl=%0b rv=%0b tv=%0b tpc=%h tc=%0d cyc=%0d ins=%0d we=%0b want all 0",
                               o_flush, o_redirect_valid, o_trap_valid, o_trap_pc, o_trap_code, o_cycle, o_instret, o_rf_wr_en); end
        i_rst_n = 1'b1;
        drive(mk(1, 64'h0, 5'd9, 1, 0, '0, '0), 64'h99, 1'b0, '0);
        checks++; if (o_rf_wr_en !== 1'b1 || o_rf_wr_idx !== 5'd9 || o_rf_wr_data !== 64'h99) begin
            errors++; $display("FAIL post_rst_wr: got we=%0b idx=%0d wd=%h want 1/9/99", o_rf_wr_en, o_rf_wr_idx, o_rf_wr_data); end
        tick();
        checks++; if (o_instret !== 64'd1 || o_cycle !== 64'd1 || o_flush !== 1'b0 || o_redirect_valid !== 1'b0) begin
            errors++; $display("FAIL post_rst_ret: got ins=%0d cyc=%0d fl=%0b rv=%0b want 1/1/0/0",
                               o_instret, o_cycle, o_flush, o_redirect_valid); end
    endtask

    task automatic test_random();
        issued_instr_t ins;
        except_code_t  code;
        for (int i = 0; i < 400; i++) begin
            code = ($urandom_range(1) == 0) ? EXCEPT_MISPRED : 5'($urandom_range(15));
            ins  = mk($urandom_range(99) < 75, {$urandom, $urandom}, 5'($urandom), 1'($urandom),
                      $urandom_range(99) < 20, code, {$urandom, $urandom});
            drive(ins, {$urandom, $urandom}, 1'($urandom_range(99) < 30), {$urandom, $urandom});
            checks++; if (o_rf_wr_en !== e_wr_en || (e_wr_en && (o_rf_wr_idx !== e_wr_idx || o_rf_wr_data !== e_wr_data))) begin
                errors++; $display("FAIL rnd_rf[%0d]: got we=%0b idx=%0d wd=%h want %0b/%0d/%h",
                                   i, o_rf_wr_en, o_rf_wr_idx, o_rf_wr_data, e_wr_en, e_wr_idx, e_wr_data); end
            tick();
            checks++; if (o_flush !== e_flush || o_redirect_valid !== e_redir || o_redirect_pc !== e_redir_pc) begin
                errors++; $display("FAIL rnd_redir[%0d]: got fl=%0b rv=%0b rpc=%h want %0b/%0b/%h",
                                   i, o_flush, o_redirect_valid, o_redirect_pc, e_flush, e_redir, e_redir_pc); end
            checks++; if (o_trap_valid !== e_trap || o_trap_code !== e_trap_code || o_trap_pc !== e_trap_pc) begin
                errors++; $display("FAIL rnd_trap[%0d]: got tv=%0b tc=%0d tpc=%h want %0b/%0d/%h",
                                   i, o_trap_valid, o_trap_code, o_trap_pc, e_trap, e_trap_code, e_trap_pc); end
            checks++; if (o_cycle !== m_cycle || o_instret !== m_instret) begin
                errors++; $display("FAIL rnd_ctr[%0d]: got cyc=%0d ins=%0d want %0d/%0d", i, o_cycle, o_instret, m_cycle, m_instret); end
        end
    endtask

    task automatic test_cycle_wrap();
        force dut.u_cycle_ctr.r_count = '1;
        #1;
        release dut.u_cycle_ctr.r_count;
        m_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
        checks++; if (o_cycle !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL wrap_load: got %h want ffffffffffffffff", o_cycle); end
        drive('0, '0, 1'b0, '0);
        tick();
        checks++; if (o_cycle !== 64'd0 || o_cycle !== m_cycle) begin
            errors++; $display("FAIL wrap_zero: got %h want 0", o_cycle); end
    endtask

    initial begin
        i_rst_n = 1'b0; i_instr = '0; i_data = '0; i_trap_ack = 1'b0; i_trap_vec = '0; i_log_fd = 32'd0;
        test_reset();
        test_normal_write();
        test_mispredict();
        test_trap();
        test_reset_in_trap_wait();
        test_random();
        test_cycle_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
